uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 143 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Byte FIFO between the pipeline's MA-stage UART store and the
//                UART transmitter. Pops one byte at a time and paces strobes
//                so that each character gets CHAR_CYCLES clocks on the line.
//  Ports       : clk         - single clock, rising edge
//                rst         - synchronous active-high reset
//                wr_en_i     - store to UART address this cycle
//                wr_data_i   - byte to enqueue
//                full_o      - FIFO holds DEPTH bytes (stall request)
//                uart_wr_o   - one-cycle send strobe to transmitter
//                uart_dat_o  - byte accompanying uart_wr_o (held until next)
//                idle_o      - FIFO empty and scheduler idle
//                overflow_o  - sticky: a write was dropped
//                count_o     - current FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int DEPTH       = 16,
    parameter int CHAR_CYCLES = 868
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [7:0]               wr_data_i,
    output logic                     full_o,
    output logic                     uart_wr_o,
    output logic [7:0]               uart_dat_o,
    output logic                     idle_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    // CHAR_CYCLES-2 always fits in clog2(CHAR_CYCLES) bits; keep at least 1.
    localparam int c_GW = (CHAR_CYCLES > 2) ? $clog2(CHAR_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_GW-1:0]    r_gap;
    logic [c_GW-1:0]    w_gap_nxt;
    logic [7:0]         r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic [7:0]         r_dat;
    logic               r_ovf;

    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    // A pop only ever happens on the IDLE->SEND edge, so an empty FIFO can
    // never pop and a same-cycle push cannot bypass into the transmitter.
    assign w_full = (r_count == c_CW'(DEPTH));
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    // A full FIFO still accepts a push if a slot frees on the same edge.
    assign w_push = wr_en_i && (!w_full || w_pop);
    assign w_drop = wr_en_i && w_full && !w_pop;

    // Next-state / gap counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                w_state_nxt = S_GAP;
                w_gap_nxt   = c_GW'(CHAR_CYCLES - 2);
            end
            S_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control state: FSM, pointers, occupancy, output byte, sticky flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gap    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dat    <= 8'h00;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dat    <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    assign full_o     = w_full;
    assign uart_wr_o  = (r_state == S_SEND);
    assign uart_dat_o = r_dat;
    assign idle_o     = (r_state == S_IDLE) && (r_count == '0);
    assign overflow_o = r_ovf;
    assign count_o    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Self-checking bench for uart_tx_scheduler. A queue-based
//                model predicts every output each cycle; directed scenarios
//                add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int DEPTH = 16;
    localparam int C     = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full_o;
    logic          uart_wr_o;
    logic [7:0]    uart_dat_o;
    logic          idle_o;
    logic          overflow_o;
    logic [CW-1:0] count_o;

    uart_tx_scheduler #(.DEPTH(DEPTH), .CHAR_CYCLES(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .full_o     (full_o),
        .uart_wr_o  (uart_wr_o),
        .uart_dat_o (uart_dat_o),
        .idle_o     (idle_o),
        .overflow_o (overflow_o),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_timer: clocks until the scheduler may start another character
    // (C on the strobe cycle, 0 when free to pop).
    int          mq[$];
    int          m_timer = 0;
    logic        m_ovf   = 1'b0;
    logic [7:0]  m_dat   = 8'h00;
    bit          chk_en  = 1'b0;

    initial begin
        bit pop;
        bit acc;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_timer = 0;
                m_ovf   = 1'b0;
                m_dat   = 8'h00;
            end else begin
                pop = (m_timer == 0) && (mq.size() > 0);
                acc = wr_en && ((mq.size() < DEPTH) || pop);
                if (pop) begin
                    m_dat   = 8'(mq.pop_front());
                    m_timer = C;
                end else if (m_timer > 0) begin
                    m_timer--;
                end
                if (acc)        mq.push_back(int'(wr_data));
                else if (wr_en) m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("uart_wr",  32'(uart_wr_o),  32'(m_timer == C));
                check("uart_dat", 32'(uart_dat_o), 32'(m_dat));
                check("count",    32'(count_o),    32'(mq.size()));
                check("full",     32'(full_o),     32'(mq.size() == DEPTH));
                check("idle",     32'(idle_o),     32'(mq.size() == 0 && m_timer == 0));
                check("overflow", 32'(overflow_o), 32'(m_ovf));
            end
        end
    end

    // Strobe recorder and occupancy peak tracker
    logic [7:0] sb[$];
    int         st[$];
    int         cyc  = 0;
    int         peak = 0;
    initial forever begin @(posedge clk); cyc++; end
    initial begin
        forever begin
            @(negedge clk);
            if (uart_wr_o === 1'b1) begin
                sb.push_back(uart_dat_o);
                st.push_back(cyc);
            end
            if (int'(count_o) > peak) peak = int'(count_o);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver helpers ----------------
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push1(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        while (uart_wr_o !== 1'b1 && n < 400) begin tick(); n++; end
        if (n >= 400) check("strobe_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (idle_o !== 1'b1 && n < 2000) begin tick(); n++; end
        if (n >= 2000) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_sb(input int want);
        int n;
        n = 0;
        while (sb.size() < want && n < 2000) begin tick(); n++; end
        tick();
        if (n >= 2000) check("strobe_count_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        int bad;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        @(negedge clk);
        tick(); tick();
        chk_en = 1'b1;
        rst    = 1'b0;

        // Reset state
        check("rst_count", 32'(count_o),    32'd0);
        check("rst_idle",  32'(idle_o),     32'd1);
        check("rst_wr",    32'(uart_wr_o),  32'd0);
        check("rst_dat",   32'(uart_dat_o), 32'h00);
        check("rst_ovf",   32'(overflow_o), 32'd0);
        check("rst_full",  32'(full_o),     32'd0);

        // Single byte: latency 2 edges from push edge, idle C clocks later
        push1(8'h41);
        wait_strobe(n);
        check("single_latency_edges", 32'(n + 1), 32'd2);
        check("single_dat",           32'(uart_dat_o), 32'h41);
        wait_idle(n);
        check("single_idle_after", 32'(n), 32'(C));

        // Burst "ABC"
        sb.delete(); st.delete(); peak = 0;
        wr_en = 1'b1;
        wr_data = 8'h41; tick();
        wr_data = 8'h42; tick();
        wr_data = 8'h43; tick();
        wr_en = 1'b0;
        wait_sb(3);
        wait_idle(n);
        check("burst_n",    32'(sb.size()), 32'd3);
        if (sb.size() == 3 && st.size() == 3) begin
            check("burst_b0",   32'(sb[0]), 32'h41);
            check("burst_b1",   32'(sb[1]), 32'h42);
            check("burst_b2",   32'(sb[2]), 32'h43);
            check("burst_gap0", 32'(st[1] - st[0]), 32'(C + 1));
            check("burst_gap1", 32'(st[2] - st[1]), 32'(C + 1));
        end
        check("burst_peak", 32'(peak), 32'd2);

        // 17 pushes during GAP: 16 accepted, 17th dropped
        sb.delete();
        push1(8'h50);
        wait_strobe(n);
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(32'h60 + i); tick();
        end
        wr_en = 1'b0;
        check("ovf_full",  32'(full_o),     32'd1);
        check("ovf_count", 32'(count_o),    32'd16);
        check("ovf_flag",  32'(overflow_o), 32'd1);
        wait_sb(17);
        wait_idle(n);
        check("ovf_tx_n", 32'(sb.size()), 32'd17);
        bad = 0;
        if (sb.size() == 17) begin
            if (sb[0] != 8'h50) bad++;
            for (int i = 0; i < 16; i++) if (sb[i + 1] != 8'(32'h60 + i)) bad++;
        end
        check("ovf_tx_order", 32'(bad), 32'd0);
        check("ovf_sticky",   32'(overflow_o), 32'd1);

        // Full FIFO with push coinciding with the pop edge
        rst = 1'b1; tick(); rst = 1'b0;
        check("clr_ovf", 32'(overflow_o), 32'd0);
        sb.delete();
        push1(8'h70);
        wait_strobe(n);
        for (int k = 1; k <= C + 1; k++) begin
            wr_en   = (k <= 16) || (k == C + 1);
            wr_data = (k <= 16) ? 8'(32'h80 + k - 1) : 8'h90;
            tick();
        end
        wr_en = 1'b0;
        check("pp_strobe", 32'(uart_wr_o),  32'd1);
        check("pp_dat",    32'(uart_dat_o), 32'h80);
        check("pp_count",  32'(count_o),    32'd16);
        check("pp_ovf",    32'(overflow_o), 32'd0);
        wait_sb(18);
        wait_idle(n);
        check("pp_tx_n", 32'(sb.size()), 32'd18);
        if (sb.size() == 18) check("pp_last", 32'(sb[17]), 32'h90);
        check("pp_ovf_end", 32'(overflow_o), 32'd0);

        // Reset during GAP with 5 bytes queued
        sb.delete();
        push1(8'hA0);
        wait_strobe(n);
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(32'hA0 + i); tick();
        end
        wr_en = 1'b0;
        tick(); tick(); tick();
        check("rg_count_pre", 32'(count_o), 32'd5);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rg_count", 32'(count_o), 32'd0);
        check("rg_idle",  32'(idle_o),  32'd1);
        repeat (100) tick();
        check("rg_no_strobe", 32'(sb.size()), 32'd1);

        // Pointer wrap: 40 bytes at pacing rate
        sb.delete();
        for (int i = 0; i < 40; i++) begin
            push1(8'(i * 5 + 1));
            repeat (C) tick();
        end
        wait_sb(40);
        wait_idle(n);
        check("wrap_n", 32'(sb.size()), 32'd40);
        bad = 0;
        if (sb.size() == 40)
            for (int i = 0; i < 40; i++) if (sb[i] != 8'(i * 5 + 1)) bad++;
        check("wrap_order", 32'(bad), 32'd0);
        check("wrap_ovf",   32'(overflow_o), 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
